// File: rtl/dsp48_pkg.sv
// Shared types and constants for the DSP48 MAC sequencer: FSM state encoding
// and the DSP48 opmode bit-field values used to build the accumulate opmode.
package dsp48_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    // Opmode layout: {post_sub, pre_sub, pre_en, carry_in, z_sel[1:0], x_sel[1:0]}
    localparam logic [1:0] OPM_X_M      = 2'b01;
    localparam logic [1:0] OPM_Z_P      = 2'b10;
    localparam logic       OPM_CARRY_0  = 1'b0;
    localparam logic       OPM_PRE_OFF  = 1'b0;
    localparam logic       OPM_PRE_ADD  = 1'b0;
    localparam logic       OPM_POST_ADD = 1'b0;

    function automatic logic [7:0] build_opmode(
        input logic       post_sub,
        input logic       pre_sub,
        input logic       pre_en,
        input logic       carry_in,
        input logic [1:0] z_sel,
        input logic [1:0] x_sel
    );
        return {post_sub, pre_sub, pre_en, carry_in, z_sel, x_sel};
    endfunction

    localparam logic [7:0] OPMODE_MAC_DEFAULT =
        build_opmode(OPM_POST_ADD, OPM_PRE_ADD, OPM_PRE_OFF, OPM_CARRY_0, OPM_Z_P, OPM_X_M);

endpackage

// File: rtl/dsp48_vld_pipe.sv
// Parameterised-depth 1-bit valid shift register; delays a sample-valid strobe
// so it lines up with the product reaching the slice's P register.
module dsp48_vld_pipe
    import dsp48_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/dsp48_mac_sequencer.sv
// Drives one DSP48 slice as a dot-product MAC: job handshake, operand stream,
// P clear/enable sequencing and result capture. Define DSP48_MAC_SEQ_OVF_EN to
// enable the sticky accumulate-carry flag on res_ovf.
module dsp48_mac_sequencer
    import dsp48_pkg::*;
#(
    parameter int         LEN_W      = 10,
    parameter int         PIPE_LAT   = 3,
    parameter logic [7:0] OPMODE_MAC = OPMODE_MAC_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    output logic             start_ready,
    input  logic [LEN_W-1:0] start_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      in_a,
    input  logic [17:0]      in_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data,
    output logic             res_ovf,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_ceopmode,
    output logic             dsp_cea,
    output logic             dsp_ceb,
    output logic             dsp_cem,
    output logic             dsp_cep,
    output logic             dsp_rstm,
    output logic             dsp_rstp,
    input  logic [47:0]      dsp_p,
    input  logic             dsp_carryout
);

    localparam int DRAIN_W = $clog2(PIPE_LAT + 1);

    seq_state_t         state, state_next;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [47:0]        res_data_q;
    logic               start_fire;
    logic               run_open;
    logic               in_fire;
    logic               drain_done;

    assign start_fire = start && (state == ST_IDLE);
    assign run_open   = (state == ST_RUN) && (cnt < len_q);
    assign in_fire    = in_valid && run_open;
    // Drain runs PIPE_LAT cycles for the last product, plus the capture cycle.
    assign drain_done = (drain_cnt == DRAIN_W'(PIPE_LAT));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            len_q      <= '0;
            cnt        <= '0;
            drain_cnt  <= '0;
            res_data_q <= '0;
        end else begin
            state <= state_next;
            if (start_fire) begin
                len_q <= start_len;
                cnt   <= '0;
            end else if (in_fire) begin
                cnt <= cnt + 1'b1;
            end
            if (state == ST_DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
            end else begin
                drain_cnt <= '0;
            end
            if ((state == ST_DRAIN) && drain_done) begin
                res_data_q <= dsp_p;
            end
        end
    end

    always_comb begin
        state_next  = state;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        dsp_rstp    = 1'b0;
        dsp_rstm    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                start_ready = 1'b1;
                if (start) state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                dsp_rstp   = 1'b1;
                dsp_rstm   = 1'b1;
                state_next = (len_q == '0) ? ST_DRAIN : ST_RUN;
            end
            ST_RUN: begin
                if (in_fire && (cnt == len_q - 1'b1)) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_done) state_next = ST_DONE;
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // P only loads when a real product arrives, so bubbles never corrupt the sum.
    dsp48_vld_pipe #(
        .DEPTH(PIPE_LAT - 1)
    ) u_cep_pipe (
        .clk  (CLK),
        .rst_n(RST_N),
        .din  (in_fire),
        .dout (dsp_cep)
    );

`ifdef DSP48_MAC_SEQ_OVF_EN
    logic cep_seen;
    logic ovf_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cep_seen <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (start_fire) begin
            cep_seen <= 1'b0;
            ovf_q    <= 1'b0;
        end else if ((state != ST_IDLE) && (state != ST_DONE)) begin
            if (dsp_cep) cep_seen <= 1'b1;
            if (cep_seen && dsp_carryout) ovf_q <= 1'b1;
        end
    end

    assign res_ovf = ovf_q;
`else
    logic ovf_unused;
    assign ovf_unused = dsp_carryout;
    assign res_ovf    = 1'b0;
`endif

    assign in_ready     = run_open;
    assign res_data     = res_data_q;
    assign dsp_a        = in_a;
    assign dsp_b        = in_b;
    assign dsp_opmode   = OPMODE_MAC;
    assign dsp_ceopmode = 1'b1;
    assign dsp_cea      = 1'b1;
    assign dsp_ceb      = 1'b1;
    assign dsp_cem      = 1'b1;

endmodule
